// File: rtl/tcp_tx_msg_noc_in_queue_if.sv
// NoC ingress / dispatch bundle for tcp_tx_msg_noc_in_queue.
// err_cnt exists only when TCP_TX_MSG_IN_TYPE_FILTER_EN is defined.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif

interface tcp_tx_msg_noc_in_queue_if #(
    parameter int DATA_W = `NOC_DATA_WIDTH,
    parameter int DEPTH  = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              noc_in_val;
    logic [DATA_W-1:0] noc_in_data;
    logic              noc_in_rdy;
    logic              poll_req_val;
    logic              poll_req_rdy;
    logic              tail_wr_val;
    logic              tail_wr_rdy;
    logic              sched_upd_val;
    logic              sched_upd_rdy;
    logic [DATA_W-1:0] cmd_data;
    logic [OCC_W-1:0]  fifo_occ;
`ifdef TCP_TX_MSG_IN_TYPE_FILTER_EN
    logic [15:0]       err_cnt;
`endif

    modport slave (
        input  noc_in_val,
        input  noc_in_data,
        input  poll_req_rdy,
        input  tail_wr_rdy,
        input  sched_upd_rdy,
`ifdef TCP_TX_MSG_IN_TYPE_FILTER_EN
        output err_cnt,
`endif
        output noc_in_rdy,
        output poll_req_val,
        output tail_wr_val,
        output sched_upd_val,
        output cmd_data,
        output fifo_occ
    );

    modport master (
        output noc_in_val,
        output noc_in_data,
        output poll_req_rdy,
        output tail_wr_rdy,
        output sched_upd_rdy,
`ifdef TCP_TX_MSG_IN_TYPE_FILTER_EN
        input  err_cnt,
`endif
        input  noc_in_rdy,
        input  poll_req_val,
        input  tail_wr_val,
        input  sched_upd_val,
        input  cmd_data,
        input  fifo_occ
    );
endinterface

// File: rtl/tcp_tx_msg_noc_in_queue.sv
// TCP TX NoC ingress: DEPTH-entry header FIFO plus in-order dispatch FSM.
// Optional unknown-type drop filter: TCP_TX_MSG_IN_TYPE_FILTER_EN.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif

module tcp_tx_msg_noc_in_queue #(
    parameter int DATA_W       = `NOC_DATA_WIDTH,
    parameter int DEPTH        = 4,
    parameter int MSG_TYPE_LSB = 0,
    parameter int MSG_TYPE_W   = 8,
    parameter logic [MSG_TYPE_W-1:0] REQ_TYPE = MSG_TYPE_W'(8'h01),
    parameter logic [MSG_TYPE_W-1:0] PTR_TYPE = MSG_TYPE_W'(8'h02)
) (
    input  logic                         clk,
    input  logic                         rst,
    tcp_tx_msg_noc_in_queue_if.slave     bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        PTR  = 2'd2,
        KICK = 2'd3
    } state_t;

    state_t               state_r;
    logic [DATA_W-1:0]    mem_r [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [OCC_W-1:0]     occ_r;
    logic [OCC_W-1:0]     occ_nxt_s;
    logic                 noc_in_rdy_r;
    logic                 poll_req_val_r;
    logic                 tail_wr_val_r;
    logic                 sched_upd_val_r;
    logic                 push_s;
    logic                 pop_s;
    logic                 empty_s;
    logic                 drop_s;
    logic                 is_req_s;
    logic                 is_ptr_s;
    logic [DATA_W-1:0]    head_s;
    logic [MSG_TYPE_W-1:0] head_type_s;

    // Head decode, handshake qualification and drop decision
    always_comb begin
        head_s      = mem_r[rd_ptr_r];
        head_type_s = head_s[MSG_TYPE_LSB +: MSG_TYPE_W];
        is_req_s    = (head_type_s == REQ_TYPE);
        is_ptr_s    = (head_type_s == PTR_TYPE);
        empty_s     = (occ_r == {OCC_W{1'b0}});
        push_s      = bus.noc_in_val && noc_in_rdy_r;
`ifdef TCP_TX_MSG_IN_TYPE_FILTER_EN
        drop_s      = (state_r == IDLE) && !empty_s && !is_req_s && !is_ptr_s;
`else
        drop_s      = 1'b0;
`endif
        // A pointer update leaves the FIFO only once its scheduler kick completes
        pop_s       = ((state_r == REQ)  && bus.poll_req_rdy)  ||
                      ((state_r == KICK) && bus.sched_upd_rdy) ||
                      drop_s;
    end

    // Occupancy next-state: a simultaneous push and pop cancel out
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + OCC_W'(1);
            2'b01:   occ_nxt_s = occ_r - OCC_W'(1);
            default: occ_nxt_s = occ_r;
        endcase
    end

    // FIFO storage; contents need no reset since occupancy gates their use
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.noc_in_data;
        end
    end

    // Pointers, occupancy and the registered not-full flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            occ_r        <= {OCC_W{1'b0}};
            noc_in_rdy_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            occ_r        <= occ_nxt_s;
            noc_in_rdy_r <= (occ_nxt_s != FULL_OCC);
        end
    end

    // Dispatch FSM with registered valid outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            poll_req_val_r  <= 1'b0;
            tail_wr_val_r   <= 1'b0;
            sched_upd_val_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (empty_s) begin
                        state_r <= IDLE;
                    end else if (is_req_s) begin
                        state_r        <= REQ;
                        poll_req_val_r <= 1'b1;
                    end else if (is_ptr_s) begin
                        state_r       <= PTR;
                        tail_wr_val_r <= 1'b1;
                    end else begin
`ifdef TCP_TX_MSG_IN_TYPE_FILTER_EN
                        state_r       <= IDLE;
`else
                        state_r       <= PTR;
                        tail_wr_val_r <= 1'b1;
`endif
                    end
                end
                REQ: begin
                    if (bus.poll_req_rdy) begin
                        state_r        <= IDLE;
                        poll_req_val_r <= 1'b0;
                    end else begin
                        state_r <= REQ;
                    end
                end
                PTR: begin
                    if (bus.tail_wr_rdy) begin
                        state_r         <= KICK;
                        tail_wr_val_r   <= 1'b0;
                        sched_upd_val_r <= 1'b1;
                    end else begin
                        state_r <= PTR;
                    end
                end
                KICK: begin
                    if (bus.sched_upd_rdy) begin
                        state_r         <= IDLE;
                        sched_upd_val_r <= 1'b0;
                    end else begin
                        state_r <= KICK;
                    end
                end
                default: begin
                    state_r         <= IDLE;
                    poll_req_val_r  <= 1'b0;
                    tail_wr_val_r   <= 1'b0;
                    sched_upd_val_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef TCP_TX_MSG_IN_TYPE_FILTER_EN
    logic [15:0] err_cnt_r;

    // Saturating count of dropped unknown-type flits
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 16'h0000;
        end else if (drop_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'h0001;
        end
    end

    assign bus.err_cnt = err_cnt_r;
`endif

    assign bus.noc_in_rdy    = noc_in_rdy_r;
    assign bus.poll_req_val  = poll_req_val_r;
    assign bus.tail_wr_val   = tail_wr_val_r;
    assign bus.sched_upd_val = sched_upd_val_r;
    assign bus.cmd_data      = head_s;
    assign bus.fifo_occ      = occ_r;

endmodule

// File: tb/tb_tcp_tx_msg_noc_in_queue.sv
// Directed self-checking bench for tcp_tx_msg_noc_in_queue (DEPTH=4).
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif

module tb_tcp_tx_msg_noc_in_queue;
    localparam int DW = `NOC_DATA_WIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tcp_tx_msg_noc_in_queue_if #(.DATA_W(DW), .DEPTH(4)) bus ();

    tcp_tx_msg_noc_in_queue #(.DATA_W(DW), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int serial      = 0;

    logic [7:0]    stim_q[$];
    logic [DW-1:0] exp_data_q[$];
    bit            exp_req_q[$];
    int n_req, n_tail, n_kick, n_drop;

    function automatic logic [DW-1:0] mkflit(input logic [7:0] t, input int id);
        logic [DW-1:0] f;
        f = '0;
        f[DW-1 -: 16] = 16'hC000 ^ id[15:0];
        f[15:8] = id[7:0] ^ 8'h5A;
        f[7:0] = t;
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++;
        if (bus.fifo_occ !== 3'd0) begin
            miscompares++; $display("FAIL reset_occ: got %0d want 0", bus.fifo_occ);
        end
        vectors++;
        if (bus.noc_in_rdy !== 1'b1) begin
            miscompares++; $display("FAIL reset_rdy: got %b want 1", bus.noc_in_rdy);
        end
        vectors++;
        if ({bus.poll_req_val, bus.tail_wr_val, bus.sched_upd_val} !== 3'b000) begin
            miscompares++; $display("FAIL reset_vals: got %b want 000",
                {bus.poll_req_val, bus.tail_wr_val, bus.sched_upd_val});
        end
`ifdef TCP_TX_MSG_IN_TYPE_FILTER_EN
        vectors++;
        if (bus.err_cnt !== 16'd0) begin
            miscompares++; $display("FAIL reset_err: got %0d want 0", bus.err_cnt);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_single_req();
        logic [DW-1:0] d;
        d = mkflit(8'h01, serial); serial++;
        bus.noc_in_val = 1'b1; bus.noc_in_data = d;
        step();
        bus.noc_in_val = 1'b0;
        vectors++;
        if (bus.fifo_occ !== 3'd1 || bus.poll_req_val !== 1'b0) begin
            miscompares++; $display("FAIL single_t1: occ %0d val %b, want occ 1 val 0",
                bus.fifo_occ, bus.poll_req_val);
        end
        step();
        vectors++;
        if (bus.poll_req_val !== 1'b1 || bus.cmd_data !== d) begin
            miscompares++; $display("FAIL single_t2: val %b cmd %h, want val 1 cmd %h",
                bus.poll_req_val, bus.cmd_data, d);
        end
        step();
        vectors++;
        if (bus.poll_req_val !== 1'b0 || bus.fifo_occ !== 3'd0) begin
            miscompares++; $display("FAIL single_t3: val %b occ %0d, want val 0 occ 0",
                bus.poll_req_val, bus.fifo_occ);
        end
    endtask

    task automatic test_ptr_stall();
        logic [DW-1:0] d;
        d = mkflit(8'h02, serial); serial++;
        bus.tail_wr_rdy = 1'b0; bus.sched_upd_rdy = 1'b0;
        bus.noc_in_val = 1'b1; bus.noc_in_data = d;
        step();
        bus.noc_in_val = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.tail_wr_val !== 1'b1 || bus.sched_upd_val !== 1'b0 ||
                bus.cmd_data !== d || bus.fifo_occ !== 3'd1) begin
                miscompares++; $display("FAIL ptr_tail[%0d]: tail %b sched %b cmd %h occ %0d, want 1 0 %h 1",
                    i, bus.tail_wr_val, bus.sched_upd_val, bus.cmd_data, bus.fifo_occ, d);
            end
            if (i == 3) bus.tail_wr_rdy = 1'b1;
            step();
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (bus.tail_wr_val !== 1'b0 || bus.sched_upd_val !== 1'b1 ||
                bus.cmd_data !== d || bus.fifo_occ !== 3'd1) begin
                miscompares++; $display("FAIL ptr_kick[%0d]: tail %b sched %b cmd %h occ %0d, want 0 1 %h 1",
                    i, bus.tail_wr_val, bus.sched_upd_val, bus.cmd_data, bus.fifo_occ, d);
            end
            if (i == 1) bus.sched_upd_rdy = 1'b1;
            step();
        end
        vectors++;
        if (bus.sched_upd_val !== 1'b0 || bus.fifo_occ !== 3'd0) begin
            miscompares++; $display("FAIL ptr_done: sched %b occ %0d, want 0 0",
                bus.sched_upd_val, bus.fifo_occ);
        end
    endtask

    task automatic test_full();
        int base;
        base = serial; serial += 6;
        bus.poll_req_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.noc_in_val = 1'b1; bus.noc_in_data = mkflit(8'h01, base + i);
            vectors++;
            if (bus.noc_in_rdy !== (i < 4)) begin
                miscompares++; $display("FAIL full_rdy[%0d]: got %b want %b", i, bus.noc_in_rdy, (i < 4));
            end
            step();
        end
        bus.noc_in_val = 1'b0;
        vectors++;
        if (bus.fifo_occ !== 3'd4 || bus.noc_in_rdy !== 1'b0 || bus.poll_req_val !== 1'b1 ||
            bus.cmd_data !== mkflit(8'h01, base)) begin
            miscompares++; $display("FAIL full_state: occ %0d rdy %b val %b cmd %h, want 4 0 1 %h",
                bus.fifo_occ, bus.noc_in_rdy, bus.poll_req_val, bus.cmd_data, mkflit(8'h01, base));
        end
        bus.poll_req_rdy = 1'b1;
        step();
        vectors++;
        if (bus.fifo_occ !== 3'd3 || bus.noc_in_rdy !== 1'b1 || bus.poll_req_val !== 1'b0) begin
            miscompares++; $display("FAIL full_after_pop: occ %0d rdy %b val %b, want 3 1 0",
                bus.fifo_occ, bus.noc_in_rdy, bus.poll_req_val);
        end
        for (int k = 1; k < 4; k++) begin
            step();
            vectors++;
            if (bus.poll_req_val !== 1'b1 || bus.cmd_data !== mkflit(8'h01, base + k)) begin
                miscompares++; $display("FAIL full_drain[%0d]: val %b cmd %h, want 1 %h",
                    k, bus.poll_req_val, bus.cmd_data, mkflit(8'h01, base + k));
            end
            step();
        end
        vectors++;
        if (bus.fifo_occ !== 3'd0) begin
            miscompares++; $display("FAIL full_empty: occ %0d want 0", bus.fifo_occ);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] req_m, tail_m, kick_m;
        req_m = '0; tail_m = '0; kick_m = '0;
        for (int c = 0; c < 10; c++) begin
            req_m[c] = bus.poll_req_val;
            bus.noc_in_val = (c < 3); bus.noc_in_data = mkflit(8'h01, serial + c);
            step();
        end
        serial += 3;
        bus.noc_in_val = 1'b0;
        vectors++;
        if (req_m !== 10'b0001010100) begin
            miscompares++; $display("FAIL b2b_req: got %b want 0001010100", req_m);
        end
        for (int c = 0; c < 10; c++) begin
            tail_m[c] = bus.tail_wr_val; kick_m[c] = bus.sched_upd_val;
            bus.noc_in_val = (c < 2); bus.noc_in_data = mkflit(8'h02, serial + c);
            step();
        end
        serial += 2;
        bus.noc_in_val = 1'b0;
        vectors++;
        if (tail_m !== 10'b0000100100 || kick_m !== 10'b0001001000) begin
            miscompares++; $display("FAIL b2b_ptr: tail %b kick %b want 0000100100 0001001000", tail_m, kick_m);
        end
    endtask

    task automatic run_stream(input bit stall, input int budget);
        int idx, cyc, kind, prev_kind;
        bit done, prev_stall;
        logic [DW-1:0] prev_cmd;
        logic [7:0] t;
        idx = 0; cyc = 0; done = 0; prev_stall = 0; prev_kind = 0; prev_cmd = '0;
        n_req = 0; n_tail = 0; n_kick = 0; n_drop = 0;
        exp_data_q.delete(); exp_req_q.delete();
        while (!done) begin
            if (stall) begin
                bus.poll_req_rdy  = ($urandom_range(0, 2) != 0);
                bus.tail_wr_rdy   = ($urandom_range(0, 2) != 0);
                bus.sched_upd_rdy = ($urandom_range(0, 2) != 0);
            end else begin
                bus.poll_req_rdy = 1'b1; bus.tail_wr_rdy = 1'b1; bus.sched_upd_rdy = 1'b1;
            end
            kind = bus.poll_req_val ? 1 : bus.tail_wr_val ? 2 : bus.sched_upd_val ? 3 : 0;
            vectors++;
            if (int'(bus.poll_req_val) + int'(bus.tail_wr_val) + int'(bus.sched_upd_val) > 1) begin
                miscompares++; $display("FAIL onehot: vals %b", {bus.poll_req_val, bus.tail_wr_val, bus.sched_upd_val});
            end
            if (prev_stall) begin
                vectors++;
                if (kind != prev_kind || bus.cmd_data !== prev_cmd) begin
                    miscompares++; $display("FAIL hold: kind %0d cmd %h, want kind %0d cmd %h",
                        kind, bus.cmd_data, prev_kind, prev_cmd);
                end
            end
            if (bus.poll_req_val && bus.poll_req_rdy) begin
                vectors++; n_req++;
                if (exp_data_q.size() == 0) begin
                    miscompares++; $display("FAIL poll_req: got cmd %h, want none", bus.cmd_data);
                end else begin
                    if (!exp_req_q[0] || bus.cmd_data !== exp_data_q[0]) begin
                        miscompares++; $display("FAIL poll_req: got cmd %h, want %h (req %b)",
                            bus.cmd_data, exp_data_q[0], exp_req_q[0]);
                    end
                    void'(exp_data_q.pop_front()); void'(exp_req_q.pop_front());
                end
            end
            if (bus.tail_wr_val && bus.tail_wr_rdy) begin
                vectors++; n_tail++;
                if (exp_data_q.size() == 0) begin
                    miscompares++; $display("FAIL tail_wr: got cmd %h, want none", bus.cmd_data);
                end else if (exp_req_q[0] || bus.cmd_data !== exp_data_q[0]) begin
                    miscompares++; $display("FAIL tail_wr: got cmd %h, want %h (req %b)",
                        bus.cmd_data, exp_data_q[0], exp_req_q[0]);
                end
            end
            if (bus.sched_upd_val && bus.sched_upd_rdy) begin
                vectors++; n_kick++;
                if (exp_data_q.size() == 0) begin
                    miscompares++; $display("FAIL sched_upd: got cmd %h, want none", bus.cmd_data);
                end else begin
                    if (exp_req_q[0] || bus.cmd_data !== exp_data_q[0]) begin
                        miscompares++; $display("FAIL sched_upd: got cmd %h, want %h (req %b)",
                            bus.cmd_data, exp_data_q[0], exp_req_q[0]);
                    end
                    void'(exp_data_q.pop_front()); void'(exp_req_q.pop_front());
                end
            end
            prev_stall = (bus.poll_req_val && !bus.poll_req_rdy) || (bus.tail_wr_val && !bus.tail_wr_rdy) ||
                         (bus.sched_upd_val && !bus.sched_upd_rdy);
            prev_kind = kind; prev_cmd = bus.cmd_data;
            if (idx < stim_q.size()) begin
                t = stim_q[idx];
                bus.noc_in_val = 1'b1; bus.noc_in_data = mkflit(t, serial);
                if (bus.noc_in_rdy) begin
`ifdef TCP_TX_MSG_IN_TYPE_FILTER_EN
                    if (t != 8'h01 && t != 8'h02) n_drop++;
                    else begin
                        exp_data_q.push_back(mkflit(t, serial)); exp_req_q.push_back(t == 8'h01);
                    end
`else
                    exp_data_q.push_back(mkflit(t, serial)); exp_req_q.push_back(t == 8'h01);
`endif
                    idx++; serial++;
                end
            end else begin
                bus.noc_in_val = 1'b0;
            end
            step();
            cyc++;
            if (idx == stim_q.size() && exp_data_q.size() == 0 && bus.fifo_occ == 3'd0 &&
                !bus.poll_req_val && !bus.tail_wr_val && !bus.sched_upd_val) begin
                done = 1;
            end else if (cyc >= budget) begin
                vectors++; miscompares++;
                $display("FAIL stream_timeout: %0d of %0d pushed, %0d outstanding after %0d cycles",
                    idx, stim_q.size(), exp_data_q.size(), cyc);
                done = 1;
            end
        end
        bus.noc_in_val = 1'b0;
        bus.poll_req_rdy = 1'b1; bus.tail_wr_rdy = 1'b1; bus.sched_upd_rdy = 1'b1;
    endtask

    task automatic test_wrap();
        stim_q.delete();
        for (int i = 0; i < 11; i++) stim_q.push_back(($urandom_range(0, 1) != 0) ? 8'h01 : 8'h02);
        run_stream(1'b1, 400);
        vectors++;
        if (n_req + n_kick != 11) begin
            miscompares++; $display("FAIL wrap_count: got %0d commands want 11", n_req + n_kick);
        end
    endtask

    task automatic test_filter();
        int exp_tail;
        stim_q.delete();
        stim_q.push_back(8'h01); stim_q.push_back(8'h07); stim_q.push_back(8'h02);
        run_stream(1'b0, 100);
`ifdef TCP_TX_MSG_IN_TYPE_FILTER_EN
        exp_tail = 1;
        vectors++;
        if (bus.err_cnt !== 16'd1) begin
            miscompares++; $display("FAIL filter_err: got %0d want 1", bus.err_cnt);
        end
`else
        exp_tail = 2;
`endif
        vectors++;
        if (n_req != 1 || n_tail != exp_tail || n_kick != exp_tail) begin
            miscompares++; $display("FAIL filter_counts: req %0d tail %0d kick %0d, want 1 %0d %0d",
                n_req, n_tail, n_kick, exp_tail, exp_tail);
        end
    endtask

    task automatic test_reset_midflight();
        bus.sched_upd_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.noc_in_val = 1'b1; bus.noc_in_data = mkflit(8'h02, serial); serial++;
            step();
        end
        bus.noc_in_val = 1'b0;
        step(); step(); step();
        vectors++;
        if (bus.sched_upd_val !== 1'b1 || bus.fifo_occ !== 3'd3) begin
            miscompares++; $display("FAIL midflight_setup: sched %b occ %0d, want 1 3",
                bus.sched_upd_val, bus.fifo_occ);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.sched_upd_rdy = 1'b1;
        vectors++;
        if ({bus.poll_req_val, bus.tail_wr_val, bus.sched_upd_val} !== 3'b000 || bus.fifo_occ !== 3'd0 ||
            bus.noc_in_rdy !== 1'b1) begin
            miscompares++; $display("FAIL midflight_reset: vals %b occ %0d rdy %b, want 000 0 1",
                {bus.poll_req_val, bus.tail_wr_val, bus.sched_upd_val}, bus.fifo_occ, bus.noc_in_rdy);
        end
`ifdef TCP_TX_MSG_IN_TYPE_FILTER_EN
        vectors++;
        if (bus.err_cnt !== 16'd0) begin
            miscompares++; $display("FAIL midflight_err: got %0d want 0", bus.err_cnt);
        end
`endif
        step(); step(); step();
        vectors++;
        if ({bus.poll_req_val, bus.tail_wr_val, bus.sched_upd_val} !== 3'b000 || bus.fifo_occ !== 3'd0) begin
            miscompares++; $display("FAIL midflight_quiet: vals %b occ %0d, want 000 0",
                {bus.poll_req_val, bus.tail_wr_val, bus.sched_upd_val}, bus.fifo_occ);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.noc_in_val = 1'b0;
        bus.noc_in_data = '0;
        bus.poll_req_rdy = 1'b1;
        bus.tail_wr_rdy = 1'b1;
        bus.sched_upd_rdy = 1'b1;
        test_reset();
        test_single_req();
        test_ptr_stall();
        test_full();
        test_back_to_back();
        test_wrap();
        test_filter();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
